regfile_wb_queue: RTL
=====================

Name: regfile_wb_queue

Overview:
- Write-side producer for the dual-write-port register file.
- Accepts completed results from execute, up to two per cycle in program order, and buffers them in an in-order FIFO.
- Drains up to two entries per cycle onto the register file write ports (wen1/rd1/wdata1, wen2/rd2/wdata2).
- Exposes a pending-write bitmap so issue logic can stall on registers with writes still in flight.

Parameters:
WIDTH, 32, data width of one register value.
NR_REG, 32, number of architectural registers; index width is clog2(NR_REG).
DEPTH, 8, FIFO entries; power of two, at least 4.

Ports:
clock  input  1  single clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
in0_valid  input  1  older incoming result is valid.
in0_rd  input  clog2(NR_REG)  destination register of the older result.
in0_data  input  WIDTH  value of the older result.
in1_valid  input  1  younger incoming result is valid.
in1_rd  input  clog2(NR_REG)  destination register of the younger result.
in1_data  input  WIDTH  value of the younger result.
in_ready  output  1  queue has at least 2 free entries.
wb_stall  input  1  hold the drain this cycle.
flush  input  1  synchronous discard of every queued entry.
wen1  output  1  write enable, port 1 (older entry).
rd1  output  clog2(NR_REG)  write index, port 1.
wdata1  output  WIDTH  write data, port 1.
wen2  output  1  write enable, port 2 (younger entry).
rd2  output  clog2(NR_REG)  write index, port 2.
wdata2  output  WIDTH  write data, port 2.
pending  output  NR_REG  bit r set when any queued entry targets r (r != 0).
count  output  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (reset low, asynchronous):
  - head, tail and count go to 0.
  - Outputs while held: wen1=0, wen2=0, pending=0, in_ready=1.
  - Reset asserted mid-operation drops all entries; nothing is written that cycle.
- in_ready:
  - Combinational from registered count: in_ready = (DEPTH - count >= 2).
  - A dequeue in the same cycle is not credited.
- Enqueue, when in_ready is 1:
  - Both valid: in0 goes at tail, in1 at tail+1.
  - Only one valid: that entry goes at tail. in1-only is compacted into tail.
  - Inputs presented while in_ready is 0 are ignored, and the producer must hold them.
  - Pointers wrap modulo DEPTH.
- Drain, when wb_stall=0 and flush=0:
  - ndeq = min(count, 2).
  - The head entry drives port 1 and head+1 drives port 2.
  - Port outputs are combinational from registered queue state.
  - wenN = slot drained AND rdN != 0.
  - An rd==0 entry is still retired but never written.
- Same-destination pair:
  - Two drained entries with rd1 == rd2 force wen1=0; only the younger value is written.
  - This must not rely on port priority inside the register file.
- wb_stall=1: no drain, wen1=wen2=0, and enqueue proceeds normally.
- flush=1:
  - No drain writes that cycle, and enqueue is ignored.
  - Next cycle: count=0, head=tail, pending=0.
  - flush dominates wb_stall.
- Occupancy update: count_next = count + nenq - ndeq. Simultaneous enqueue and dequeue is legal.
- count never exceeds DEPTH; overflow is impossible by construction of in_ready.
- Latency and visibility:
  - A result enqueued at edge N appears on the write ports during cycle N+1 (queue previously empty, no stall).
  - It is written at edge N+1 and readable combinationally from cycle N+1 onward.
- pending: combinational OR over valid entries of one-hot(rd); bit 0 is always 0.
- Unused entry storage needs no reset. Only pointers, count and valid bits are reset.

Decomposition:
- Shared package/config header holds WIDTH, NR_REG, the register index width, and a wb_entry typedef {rd, data}.
- One natural sub-module: regfile_wb_fifo_mem, a DEPTH-entry storage array with two write ports and two read ports.
- Pointer/count control, conflict suppression and the pending bitmap stay in the top level.

Test Plan:
- Reset low mid-stream with count=5 -> next cycles: wen1=wen2=0, count=0, pending=0, in_ready=1.
- Enqueue {r3=0x11, r4=0x22} at edge 0 -> cycle 1: wen1=1 rd1=3 wdata1=0x11, wen2=1 rd2=4 wdata2=0x22; cycle 2: count=0.
- Enqueue {r5=0xA, r5=0xB} -> drain cycle: wen1=0, wen2=1 rd2=5 wdata2=0xB; pending[5] clears after the drain.
- Enqueue {r0=0xFF, r7=0x1} -> drain cycle: wen1=0, wen2=1 rd2=7; count returns to 0.
- Hold wb_stall=1 while enqueuing 2 per cycle -> count reaches 8 after 4 edges with in_ready=0 from count 7 onward; further inputs are ignored; release stall -> 2 retire per cycle in order, pointers wrap correctly.
- count=6, flush=1 and in0_valid=1 in the same cycle -> no wen, next cycle count=0, pending=0, and the in0 value is never written.

Source files
------------

// File: rtl/regfile_wb_queue_pkg.sv
// Shared configuration for the register-file write-back queue: register geometry,
// the queued entry type and a one-hot helper for the pending bitmap.
package regfile_wb_queue_pkg;

   localparam int unsigned WIDTH    = 32;
   localparam int unsigned NR_REG   = 32;
   localparam int unsigned IDX_W    = $clog2(NR_REG);
   localparam int unsigned WB_DEPTH = 8;

   typedef logic [IDX_W-1:0] reg_idx_t;

   typedef struct packed {
      reg_idx_t         rd;
      logic [WIDTH-1:0] data;
   } wb_entry_t;

   function automatic logic [NR_REG-1:0] reg_onehot(input reg_idx_t r);
      logic [NR_REG-1:0] oh;
      oh    = '0;
      oh[r] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/regfile_wb_fifo_mem.sv
// Write-back queue storage: DEPTH entries, two write ports, two read ports, plus a
// view of every entry's destination index for the pending bitmap. No reset needed.
module regfile_wb_fifo_mem
   import regfile_wb_queue_pkg::*;
#(
   parameter int unsigned DEPTH = WB_DEPTH
) (
   input  logic                     clock,
   input  logic                     we_a,
   input  logic [$clog2(DEPTH)-1:0] waddr_a,
   input  wb_entry_t                wdata_a,
   input  logic                     we_b,
   input  logic [$clog2(DEPTH)-1:0] waddr_b,
   input  wb_entry_t                wdata_b,
   input  logic [$clog2(DEPTH)-1:0] raddr_a,
   input  logic [$clog2(DEPTH)-1:0] raddr_b,
   output wb_entry_t                rdata_a,
   output wb_entry_t                rdata_b,
   output reg_idx_t                 rd_all [DEPTH]
);

   wb_entry_t mem_q [DEPTH];
   wb_entry_t mem_d [DEPTH];

   // The two write addresses are always distinct (tail and tail+1).
   always_comb begin
      mem_d = mem_q;
      if (we_a) mem_d[waddr_a] = wdata_a;
      if (we_b) mem_d[waddr_b] = wdata_b;
   end

   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   assign rdata_a = mem_q[raddr_a];
   assign rdata_b = mem_q[raddr_b];

   always_comb begin
      for (int i = 0; i < DEPTH; i++) rd_all[i] = mem_q[i].rd;
   end

endmodule

// File: rtl/regfile_wb_queue.sv
// In-order write-back queue feeding the dual-write-port register file: up to two
// results accepted and two retired per cycle, with a pending-write bitmap for issue.
module regfile_wb_queue
   import regfile_wb_queue_pkg::*;
#(
   parameter int unsigned DEPTH = WB_DEPTH
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   in0_valid,
   input  logic [IDX_W-1:0]       in0_rd,
   input  logic [WIDTH-1:0]       in0_data,
   input  logic                   in1_valid,
   input  logic [IDX_W-1:0]       in1_rd,
   input  logic [WIDTH-1:0]       in1_data,
   output logic                   in_ready,
   input  logic                   wb_stall,
   input  logic                   flush,
   output logic                   wen1,
   output logic [IDX_W-1:0]       rd1,
   output logic [WIDTH-1:0]       wdata1,
   output logic                   wen2,
   output logic [IDX_W-1:0]       rd2,
   output logic [WIDTH-1:0]       wdata2,
   output logic [NR_REG-1:0]      pending,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             accept;
   logic             drain_en;
   logic [1:0]       nenq;
   logic [1:0]       ndeq;
   logic             slot1, slot2, same_rd;

   logic             we_a, we_b;
   logic [PTR_W-1:0] waddr_a, waddr_b;
   wb_entry_t        wdata_a, wdata_b;
   wb_entry_t        e_head, e_next;
   reg_idx_t         rd_all [DEPTH];
   logic [PTR_W-1:0] offset;

   regfile_wb_fifo_mem #(.DEPTH(DEPTH)) u_mem (
      .clock   (clock),
      .we_a    (we_a),
      .waddr_a (waddr_a),
      .wdata_a (wdata_a),
      .we_b    (we_b),
      .waddr_b (waddr_b),
      .wdata_b (wdata_b),
      .raddr_a (head_q),
      .raddr_b (head_q + PTR_W'(1)),
      .rdata_a (e_head),
      .rdata_b (e_next),
      .rd_all  (rd_all)
   );

   // Registered count only: a same-cycle dequeue does not free space.
   assign in_ready = (DEPTH_C - count_q) >= CNT_W'(2);
   assign count    = count_q;

   // A lone in1 is compacted into the tail slot.
   always_comb begin
      accept  = in_ready && !flush;
      we_a    = accept && in0_valid;
      waddr_a = tail_q;
      wdata_a = '{rd: in0_rd, data: in0_data};
      we_b    = accept && in1_valid;
      waddr_b = in0_valid ? tail_q + PTR_W'(1) : tail_q;
      wdata_b = '{rd: in1_rd, data: in1_data};
      nenq    = {1'b0, we_a} + {1'b0, we_b};
   end

   // A same-destination pair writes only the younger value, independent of
   // whatever port priority the register file has.
   always_comb begin
      drain_en = !wb_stall && !flush;
      if (!drain_en)                     ndeq = 2'd0;
      else if (count_q >= CNT_W'(2))     ndeq = 2'd2;
      else                               ndeq = count_q[1:0];
      slot1   = ndeq != 2'd0;
      slot2   = ndeq == 2'd2;
      same_rd = slot2 && (e_head.rd == e_next.rd);
      wen1    = slot1 && (e_head.rd != '0) && !same_rd;
      wen2    = slot2 && (e_next.rd != '0);
      rd1     = e_head.rd;
      wdata1  = e_head.data;
      rd2     = e_next.rd;
      wdata2  = e_next.data;
   end

   always_comb begin
      count_d = count_q + CNT_W'(nenq) - CNT_W'(ndeq);
      head_d  = head_q + PTR_W'(ndeq);
      tail_d  = tail_q + PTR_W'(nenq);
      if (flush) begin
         count_d = '0;
         head_d  = tail_q;
         tail_d  = tail_q;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // An entry is live when its distance from head is below the occupancy.
   always_comb begin
      pending = '0;
      offset  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset = PTR_W'(i) - head_q;
         if ({1'b0, offset} < count_q) pending = pending | reg_onehot(rd_all[i]);
      end
      pending[0] = 1'b0;
   end

endmodule
